// File: rtl/cmp_arb_pkg.sv
// cmp_arb_pkg: shared defaults, FSM encoding and miss-counter width for the compare arbiter.
package cmp_arb_pkg;
  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 6;
  localparam int MISS_W    = 8;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;
endpackage

// File: rtl/cmp_arb_eq.sv
// cmp_eq: WIDTH-bit combinational equality comparator with enable.
module cmp_eq
  import cmp_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq
);
  assign eq = en & (a == b);
endmodule

// File: rtl/cmp_arb.sv
// cmp_arb: round-robin arbiter feeding a shared equality comparator with a one-entry result slot.
// Optional macro CMP_ARB_MISS_CNT_EN adds a saturating count of drained mismatches on miss_cnt.
module cmp_arb
  import cmp_arb_pkg::*;
#(
  parameter  int NREQ  = NREQ_DEF,
  parameter  int WIDTH = WIDTH_DEF,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmp_en,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
`ifdef CMP_ARB_MISS_CNT_EN
  output logic [MISS_W-1:0]     miss_cnt,
`endif
  output logic                  rsp_eq
);
  state_e                state_q, state_d;
  logic [IDW-1:0]        rr_ptr_q, rr_ptr_d, rsp_id_q, rsp_id_d, gnt_idx;
  logic                  rsp_eq_q, rsp_eq_d, found, grant, drain, eq;
  logic [2*NREQ-1:0]     dbl;
  logic [WIDTH-1:0]      a_sel, b_sel;
  int                    off;
  // Rotating the doubled request vector by rr_ptr turns the search into "lowest set bit".
  always_comb begin
    dbl   = {req_valid, req_valid} >> rr_ptr_q;
    found = 1'b0;
    off   = 0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (dbl[k]) begin
        found = 1'b1;
        off   = k;
      end
    gnt_idx = IDW'((int'(rr_ptr_q) + off) % NREQ);
  end
  assign drain = (state_q == FULL) & rsp_ready;
  assign grant = found & cmp_en & reset_n & ((state_q == EMPTY) | rsp_ready);
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      req_ready[k] = grant & (gnt_idx == IDW'(k));
      if (gnt_idx == IDW'(k)) begin
        a_sel = req_a[k*WIDTH +: WIDTH];
        b_sel = req_b[k*WIDTH +: WIDTH];
      end
    end
  end
  cmp_eq #(.WIDTH(WIDTH)) u_eq (.en(grant), .a(a_sel), .b(b_sel), .eq(eq));
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state_q <= EMPTY;
    else          state_q <= state_d;
  always_comb state_d = grant ? FULL : drain ? EMPTY : state_q;
  always_comb rsp_valid = (state_q == FULL);
  always_comb begin
    rr_ptr_d = grant ? IDW'((int'(gnt_idx) + 1) % NREQ) : rr_ptr_q;
    rsp_id_d = grant ? gnt_idx : rsp_id_q;
    rsp_eq_d = grant ? eq : rsp_eq_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rr_ptr_q <= '0;
      rsp_id_q <= '0;
      rsp_eq_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      rsp_id_q <= rsp_id_d;
      rsp_eq_q <= rsp_eq_d;
    end
  assign rsp_id = rsp_id_q;
  assign rsp_eq = rsp_eq_q;
`ifdef CMP_ARB_MISS_CNT_EN
  logic [MISS_W-1:0] miss_q, miss_d;
  always_comb miss_d = (drain & ~rsp_eq_q & ~&miss_q) ? miss_q + 1'b1 : miss_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) miss_q <= '0;
    else          miss_q <= miss_d;
  assign miss_cnt = miss_q;
`endif
endmodule

// File: tb/tb_cmp_arb.sv
// tb_cmp_arb: directed scoreboard bench for cmp_arb (NREQ=4, WIDTH=6); miss counter checked when CMP_ARB_MISS_CNT_EN is defined.
module tb_cmp_arb;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmp_en;
  logic [3:0]  req_valid;
  logic [23:0] req_a, req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid, rsp_ready, rsp_eq;
  logic [1:0]  rsp_id;
`ifdef CMP_ARB_MISS_CNT_EN
  logic [7:0]  miss_cnt;
`endif
  int          n_chk = 0;
  int          n_fail = 0;
  logic [2:0]  sb[$];

  cmp_arb #(.NREQ(4), .WIDTH(6)) dut (
    .clk(clk), .reset_n(reset_n), .cmp_en(cmp_en), .req_valid(req_valid),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id),
`ifdef CMP_ARB_MISS_CNT_EN
    .miss_cnt(miss_cnt),
`endif
    .rsp_eq(rsp_eq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (reset_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) chk("unexpected_rsp", 1, 0);
      else begin
        logic [2:0] e;
        e = sb.pop_front();
        chk("rsp_id", {30'd0, rsp_id}, {30'd0, e[2:1]});
        chk("rsp_eq", {31'd0, rsp_eq}, {31'd0, e[0]});
      end
    end

  task automatic cyc(input logic en, input logic rr, input logic [3:0] v,
                     input logic [23:0] a, input logic [23:0] b,
                     input logic [3:0] exp_rdy, input logic [1:0] eid, input logic eeq);
    cmp_en = en; rsp_ready = rr; req_valid = v; req_a = a; req_b = b;
    @(negedge clk);
    chk("req_ready", {28'd0, req_ready}, {28'd0, exp_rdy});
    if (exp_rdy != 4'd0) sb.push_back({eid, eeq});
    @(posedge clk);
    #1;
  endtask

  task automatic held(input logic [1:0] eid, input logic eeq);
    chk("hold_valid", {31'd0, rsp_valid}, 1);
    chk("hold_id", {30'd0, rsp_id}, {30'd0, eid});
    chk("hold_eq", {31'd0, rsp_eq}, {31'd0, eeq});
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    sb.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; cmp_en = 1'b1; req_valid = 4'b1111; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    #3;
    chk("rst_valid", {31'd0, rsp_valid}, 0);
    chk("rst_id", {30'd0, rsp_id}, 0);
    chk("rst_eq", {31'd0, rsp_eq}, 0);
    chk("rst_ready", {28'd0, req_ready}, 0);
    repeat (2) @(posedge clk);
    #1;
    req_valid = 4'd0;
    reset_n = 1'b1;
    // Single request, equal operands on lane 2
    cyc(1, 1, 4'b0100, {6'o0, 6'o52, 6'o0, 6'o0}, {6'o0, 6'o52, 6'o0, 6'o0}, 4'b0100, 2'd2, 1'b1);
    cyc(1, 1, 4'b0000, '0, '0, 4'b0000, 2'd0, 1'b0);
    // Round robin from pointer 0; lanes 0,2 equal, lanes 1,3 differ
    do_reset();
    for (int i = 0; i < 5; i++)
      cyc(1, 1, 4'b1111, {6'd10, 6'd10, 6'd10, 6'd10}, {6'd12, 6'd10, 6'd11, 6'd10},
          4'b0001 << (i % 4), 2'(i % 4), (i % 2) == 0);
    cyc(1, 1, 4'b0000, '0, '0, 4'b0000, 2'd0, 1'b0);
    // Backpressure: pointer is 1, lane 1 A=5 B=4
    cyc(1, 1, 4'b0010, {6'd0, 6'd0, 6'd5, 6'd0}, {6'd0, 6'd0, 6'd4, 6'd0}, 4'b0010, 2'd1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cyc(1, 0, 4'b0010, {6'd0, 6'd0, 6'd7, 6'd0}, {6'd0, 6'd0, 6'd7, 6'd0}, 4'b0000, 2'd0, 1'b0);
      held(2'd1, 1'b0);
    end
    cyc(1, 1, 4'b0010, {6'd0, 6'd0, 6'd7, 6'd0}, {6'd0, 6'd0, 6'd7, 6'd0}, 4'b0010, 2'd1, 1'b1);
    // Enable gating
    for (int i = 0; i < 3; i++)
      cyc(0, 1, 4'b0010, {6'd0, 6'd0, 6'd5, 6'd0}, {6'd0, 6'd0, 6'd4, 6'd0}, 4'b0000, 2'd0, 1'b0);
    cyc(1, 1, 4'b0010, {6'd0, 6'd0, 6'd5, 6'd0}, {6'd0, 6'd0, 6'd4, 6'd0}, 4'b0010, 2'd1, 1'b0);
    // Enable dropped while FULL: result still held, then drains
    cyc(0, 0, 4'b0000, '0, '0, 4'b0000, 2'd0, 1'b0);
    held(2'd1, 1'b0);
    cyc(0, 1, 4'b0000, '0, '0, 4'b0000, 2'd0, 1'b0);
    chk("drained", {31'd0, rsp_valid}, 0);
    // Reset mid-operation while FULL
    cyc(1, 0, 4'b1000, '0, '0, 4'b1000, 2'd3, 1'b1);
    req_valid = 4'b1010;
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, rsp_valid}, 0);
    chk("midrst_ready", {28'd0, req_ready}, 0);
    sb.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc(1, 1, 4'b1010, '0, '0, 4'b0010, 2'd1, 1'b1);
    cyc(1, 1, 4'b0000, '0, '0, 4'b0000, 2'd0, 1'b0);
`ifdef CMP_ARB_MISS_CNT_EN
    do_reset();
    for (int i = 0; i < 300; i++)
      cyc(1, 1, 4'b0001, 24'd1, 24'd0, 4'b0001, 2'd0, 1'b0);
    cyc(1, 1, 4'b0000, '0, '0, 4'b0000, 2'd0, 1'b0);
    chk("miss_sat", {24'd0, miss_cnt}, 255);
    for (int i = 0; i < 3; i++)
      cyc(1, 1, 4'b0001, 24'd9, 24'd9, 4'b0001, 2'd0, 1'b1);
    cyc(1, 1, 4'b0000, '0, '0, 4'b0000, 2'd0, 1'b0);
    chk("miss_hold", {24'd0, miss_cnt}, 255);
`endif
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
